// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters.
// Operations are accepted one at a time over valid/ready, and the operand
// registers drive the ALU. The result and zero flag are captured and then
// returned on the winner's response channel.
// Build option: define ALU_ARB_FIXED_PRIO_EN so that requester 0 always wins
// a tie. When it is undefined, a tie goes to the requester not granted last.
//
// state | meaning
// IDLE  | waiting for a request; the winner sees ready and its operands are captured
// EXEC  | operand registers drive the ALU; its result is captured on the edge
// RESP  | response held valid until the granted requester's ready
module alu_share_arb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [DATA_WIDTH-1:0] req0_op1_i,
    input  logic [DATA_WIDTH-1:0] req0_op2_i,
    input  logic [2:0]            req0_ctrl_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [DATA_WIDTH-1:0] req1_op1_i,
    input  logic [DATA_WIDTH-1:0] req1_op2_i,
    input  logic [2:0]            req1_ctrl_i,
    output logic                  resp0_valid_o,
    input  logic                  resp0_ready_i,
    output logic [DATA_WIDTH-1:0] resp0_result_o,
    output logic                  resp0_zero_o,
    output logic                  resp1_valid_o,
    input  logic                  resp1_ready_i,
    output logic [DATA_WIDTH-1:0] resp1_result_o,
    output logic                  resp1_zero_o,
    output logic [DATA_WIDTH-1:0] alu_op1_o,
    output logic [DATA_WIDTH-1:0] alu_op2_o,
    output logic [2:0]            alu_ctrl_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_zero_i
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic                  grant_q;
    logic                  last_grant_q;
    logic                  win1;
    logic                  any_valid;
    logic                  resp_done;
    logic [DATA_WIDTH-1:0] op1_q, op2_q;
    logic [2:0]            ctrl_q;
    logic                  resp0_valid_q, resp1_valid_q;
    logic [DATA_WIDTH-1:0] resp0_result_q, resp1_result_q;
    logic                  resp0_zero_q, resp1_zero_q;

    assign any_valid = req0_valid_i || req1_valid_i;
    assign resp_done = grant_q ? resp1_ready_i : resp0_ready_i;

    // Choose the requester that would be granted if the block were in IDLE.
    always_comb begin
        win1 = req1_valid_i;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (req0_valid_i) begin
            win1 = 1'b0;
        end
`else
        if (req0_valid_i && req1_valid_i) begin
            win1 = (last_grant_q == 1'b0);
        end
`endif
    end

    // Register the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Compute the next state and the ready outputs. Ready is asserted only in IDLE.
    always_comb begin
        state_d      = state_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req0_ready_o = !win1;
                    req1_ready_o = win1;
                    state_d      = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (resp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand, grant and response registers. On reset they are cleared, so any in-flight operation is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            op1_q          <= '0;
            op2_q          <= '0;
            ctrl_q         <= '0;
            resp0_valid_q  <= 1'b0;
            resp1_valid_q  <= 1'b0;
            resp0_result_q <= '0;
            resp1_result_q <= '0;
            resp0_zero_q   <= 1'b0;
            resp1_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        grant_q <= win1;
                        op1_q   <= win1 ? req1_op1_i  : req0_op1_i;
                        op2_q   <= win1 ? req1_op2_i  : req0_op2_i;
                        ctrl_q  <= win1 ? req1_ctrl_i : req0_ctrl_i;
                    end
                end
                EXEC: begin
                    if (grant_q) begin
                        resp1_valid_q  <= 1'b1;
                        resp1_result_q <= alu_result_i;
                        resp1_zero_q   <= alu_zero_i;
                    end else begin
                        resp0_valid_q  <= 1'b1;
                        resp0_result_q <= alu_result_i;
                        resp0_zero_q   <= alu_zero_i;
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        last_grant_q  <= grant_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_op1_o      = op1_q;
    assign alu_op2_o      = op2_q;
    assign alu_ctrl_o     = ctrl_q;
    assign resp0_valid_o  = resp0_valid_q;
    assign resp1_valid_o  = resp1_valid_q;
    assign resp0_result_o = resp0_result_q;
    assign resp1_result_o = resp1_result_q;
    assign resp0_zero_o   = resp0_zero_q;
    assign resp1_zero_o   = resp1_zero_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: a table of single operations, a scoreboard of expected
// responses, and hand-written sequences for stall, tie, reset and RESP
// overlap. A behavioural ALU sits on the alu_* ports.
module tb_alu_share_arb;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid_i, req1_valid_i;
    logic          req0_ready_o, req1_ready_o;
    logic [DW-1:0] req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
    logic [2:0]    req0_ctrl_i, req1_ctrl_i;
    logic          resp0_valid_o, resp1_valid_o, resp0_ready_i, resp1_ready_i;
    logic [DW-1:0] resp0_result_o, resp1_result_o;
    logic          resp0_zero_o, resp1_zero_o;
    logic [DW-1:0] alu_op1_o, alu_op2_o, alu_result_i;
    logic [2:0]    alu_ctrl_o;
    logic          alu_zero_i;

    typedef struct {
        int          id;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  ctrl;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    vec_t vecs[10];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_op1_i(req0_op1_i), .req0_op2_i(req0_op2_i), .req0_ctrl_i(req0_ctrl_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_op1_i(req1_op1_i), .req1_op2_i(req1_op2_i), .req1_ctrl_i(req1_ctrl_i),
        .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i),
        .resp0_result_o(resp0_result_o), .resp0_zero_o(resp0_zero_o),
        .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i),
        .resp1_result_o(resp1_result_o), .resp1_zero_o(resp1_zero_o),
        .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
    );

    // Behavioural ALU: wrap-around add/sub, unsigned SLT, and unknown codes act as ADD.
    always_comb begin
        case (alu_ctrl_o)
            3'd1:    alu_result_i = alu_op1_o - alu_op2_o;
            3'd2:    alu_result_i = alu_op1_o & alu_op2_o;
            3'd3:    alu_result_i = alu_op1_o | alu_op2_o;
            3'd5:    alu_result_i = {31'd0, (alu_op1_o < alu_op2_o)};
            default: alu_result_i = alu_op1_o + alu_op2_o;
        endcase
        alu_zero_i = (alu_result_i == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic rv(input int id);
        return (id == 0) ? resp0_valid_o : resp1_valid_o;
    endfunction

    task automatic pop_check(input int id, input logic [31:0] res, input logic zero);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: requester %0d produced %h with nothing expected", id, res);
        end else begin
            e = sb_q.pop_front();
            chk("resp_id", id, e.id);
            chk("resp_result", res, e.res);
            chk("resp_zero", {31'd0, zero}, {31'd0, e.zero});
        end
    endtask

    // Scoreboard monitor: each completed response handshake is compared with the oldest expectation.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            if (resp0_valid_o && resp0_ready_i) pop_check(0, resp0_result_o, resp0_zero_o);
            if (resp1_valid_o && resp1_ready_i) pop_check(1, resp1_result_o, resp1_zero_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        if (id == 0) begin
            req0_valid_i = 1'b1; req0_op1_i = a; req0_op2_i = b; req0_ctrl_i = c;
        end else begin
            req1_valid_i = 1'b1; req1_op1_i = a; req1_op2_i = b; req1_ctrl_i = c;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic [31:0] er, input logic ez);
        logic got;
        got = 1'b0;
        @(negedge clk);
        drive(id, a, b, c);
        #1;
        for (int k = 0; k < 20; k++) begin
            if ((id == 0 && req0_ready_o) || (id == 1 && req1_ready_o)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: requester %0d never saw ready, expected ready", id);
            req0_valid_i = 1'b0;
            req1_valid_i = 1'b0;
            return;
        end
        chk("loser_ready_low", (id == 0) ? req1_ready_o : req0_ready_o, 0);
        sb_q.push_back('{id, er, ez});
        @(negedge clk);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        #1;
        chk("exec_alu_op1", alu_op1_o, a);
        chk("exec_alu_op2", alu_op2_o, b);
        chk("exec_alu_ctrl", {29'd0, alu_ctrl_o}, {29'd0, c});
        chk("exec_resp_valid_low", {31'd0, rv(id)}, 0);
        @(negedge clk);
        #1;
        chk("resp_valid_latency", {31'd0, rv(id)}, 1);
        chk("other_resp_valid_low", {31'd0, rv(1 - id)}, 0);
    endtask

    initial begin
        int grants[$];
        int gcyc[$];
        int exp_g;

        vecs[0] = '{0, 32'd5,          32'd7,          3'd0, 32'd12,         1'b0};
        vecs[1] = '{1, 32'd9,          32'd9,          3'd1, 32'd0,          1'b1};
        vecs[2] = '{0, 32'd3,          32'hFFFF_FFFF,  3'd5, 32'd1,          1'b0};
        vecs[3] = '{1, 32'd2,          32'd3,          3'd7, 32'd5,          1'b0};
        vecs[4] = '{0, 32'h0000_00F0,  32'h0000_000F,  3'd2, 32'd0,          1'b1};
        vecs[5] = '{1, 32'h0000_00F0,  32'h0000_000F,  3'd3, 32'h0000_00FF,  1'b0};
        vecs[6] = '{0, 32'd0,          32'd1,          3'd1, 32'hFFFF_FFFF,  1'b0};
        vecs[7] = '{1, 32'hFFFF_FFFF,  32'd1,          3'd0, 32'd0,          1'b1};
        vecs[8] = '{0, 32'd5,          32'd3,          3'd5, 32'd0,          1'b1};
        vecs[9] = '{1, 32'd3,          32'd5,          3'd1, 32'hFFFF_FFFE,  1'b0};

        rst = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_op1_i = '0; req0_op2_i = '0; req0_ctrl_i = '0;
        req1_op1_i = '0; req1_op2_i = '0; req1_ctrl_i = '0;
        resp0_ready_i = 1'b1; resp1_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req0_ready", {31'd0, req0_ready_o}, 0);
        chk("rst_req1_ready", {31'd0, req1_ready_o}, 0);
        chk("rst_resp0_valid", {31'd0, resp0_valid_o}, 0);
        chk("rst_resp1_valid", {31'd0, resp1_valid_o}, 0);
        chk("rst_alu_op1", alu_op1_o, 0);
        chk("rst_alu_op2", alu_op2_o, 0);
        chk("rst_alu_ctrl", {29'd0, alu_ctrl_o}, 0);
        chk("rst_resp0_result", resp0_result_o, 0);
        chk("rst_resp1_zero", {31'd0, resp1_zero_o}, 0);

        // Table of single operations, one at a time, with response ready held high.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].id, vecs[i].op1, vecs[i].op2, vecs[i].ctrl, vecs[i].res, vecs[i].zero);
            drain();
        end

        // Stall the requester 1 response for four cycles. The requester 0 ready stays high and must be ignored.
        resp1_ready_i = 1'b0;
        do_op(1, 32'd9, 32'd9, 3'd1, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            chk("stall_valid", {31'd0, resp1_valid_o}, 1);
            chk("stall_result", resp1_result_o, 0);
            chk("stall_zero", {31'd0, resp1_zero_o}, 1);
        end
        #1;
        resp1_ready_i = 1'b1;
        @(negedge clk);
        #1;
        chk("stall_valid_cleared", {31'd0, resp1_valid_o}, 0);
        chk("stall_result_held", resp1_result_o, 0);
        chk("stall_zero_held", {31'd0, resp1_zero_o}, 1);
        drain();

        // Both requesters valid continuously, starting from reset.
        do_reset();
        @(negedge clk);
        drive(0, 32'd1, 32'd1, 3'd0);
        drive(1, 32'd2, 32'd2, 3'd0);
        for (int k = 0; k < 40 && grants.size() < 4; k++) begin
            #1;
            if (req0_ready_o && req1_ready_o) begin
                n_checks++;
                n_fail++;
                $display("FAIL both_ready: both readies high, expected at most one");
            end else if (req0_ready_o) begin
                grants.push_back(0); gcyc.push_back(k); sb_q.push_back('{0, 32'd2, 1'b0});
            end else if (req1_ready_o) begin
                grants.push_back(1); gcyc.push_back(k); sb_q.push_back('{1, 32'd4, 1'b0});
            end
            @(negedge clk);
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        chk("tie_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            chk("tie_grant_order", grants[i], exp_g);
            if (i > 0) chk("tie_grant_spacing", gcyc[i] - gcyc[i-1], 3);
        end
        drain();

        // Reset during EXEC discards the operation; the next tie goes to requester 0.
        @(negedge clk);
        drive(1, 32'd3, 32'd3, 3'd0);
        #1;
        chk("pre_rst_accept", {31'd0, req1_ready_o}, 1);
        @(negedge clk);
        req1_valid_i = 1'b0;
        #1;
        chk("pre_rst_exec_op1", alu_op1_o, 3);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_resp0_valid", {31'd0, resp0_valid_o}, 0);
        chk("mid_rst_resp1_valid", {31'd0, resp1_valid_o}, 0);
        chk("mid_rst_req0_ready", {31'd0, req0_ready_o}, 0);
        chk("mid_rst_req1_ready", {31'd0, req1_ready_o}, 0);
        chk("mid_rst_alu_op1", alu_op1_o, 0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_resp", {31'd0, resp1_valid_o | resp0_valid_o}, 0);
        end
        @(negedge clk);
        drive(0, 32'd6, 32'd6, 3'd0);
        drive(1, 32'd7, 32'd7, 3'd0);
        #1;
        chk("post_rst_tie_req0", {31'd0, req0_ready_o}, 1);
        chk("post_rst_tie_req1", {31'd0, req1_ready_o}, 0);
        sb_q.push_back('{0, 32'd12, 1'b0});
        @(negedge clk);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        drain();

        // A requester 0 request arriving during RESP of requester 1 waits for IDLE.
        resp1_ready_i = 1'b0;
        do_op(1, 32'd10, 32'd20, 3'd0, 32'd30, 1'b0);
        drive(0, 32'd50, 32'd8, 3'd1);
        #1;
        chk("resp_hold_req0_ready_a", {31'd0, req0_ready_o}, 0);
        @(negedge clk);
        #1;
        chk("resp_hold_req0_ready_b", {31'd0, req0_ready_o}, 0);
        #1;
        resp1_ready_i = 1'b1;
        @(negedge clk);
        #1;
        chk("resp_done_req0_ready", {31'd0, req0_ready_o}, 1);
        sb_q.push_back('{0, 32'd42, 1'b0});
        @(negedge clk);
        req0_valid_i = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
